// File: rtl/lsu.sv
// rtl/lsu.sv - RV32I load/store unit between execute and the register-file write port
// One access in flight; word-aligned memory requests with byte lanes, load extension, error pulses.
module lsu #(
   parameter int TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [4:0]  req_rd,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_wmask,
   input  logic        mem_gnt,
   input  logic        mem_rvalid,
   input  logic [31:0] mem_rdata,
   output logic        rf_en,
   output logic [4:0]  rd,
   output logic [31:0] wdata,
   output logic        err,
   output logic [1:0]  err_cause
);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;

   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

   state_t        state_q, state_d;
   logic          we_q, we_d;
   logic [2:0]    funct3_q, funct3_d;
   logic [31:0]   addr_q, addr_d;
   logic [31:0]   wdata_q, wdata_d;
   logic [3:0]    wmask_q, wmask_d;
   logic [4:0]    rd_q, rd_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          rf_en_q, rf_en_d;
   logic [31:0]   rdata_q, rdata_d;
   logic          err_q, err_d;
   logic [1:0]    cause_q, cause_d;

   logic          illegal, misaligned;
   logic [7:0]    byte_v;
   logic [15:0]   half_v;
   logic [31:0]   ld_val;

   always_comb begin
      illegal = req_we ? (req_funct3 > 3'b010)
                       : (req_funct3 == 3'b011 || req_funct3 == 3'b110 || req_funct3 == 3'b111);
      misaligned = (req_funct3[1:0] == 2'b01 && req_addr[0]) ||
                   (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00);
   end

   always_comb begin
      byte_v = mem_rdata[{addr_q[1:0], 3'b000} +: 8];
      half_v = mem_rdata[{addr_q[1], 4'b0000} +: 16];
      case (funct3_q)
         3'b000:  ld_val = {{24{byte_v[7]}}, byte_v};
         3'b001:  ld_val = {{16{half_v[15]}}, half_v};
         3'b100:  ld_val = {24'h0, byte_v};
         3'b101:  ld_val = {16'h0, half_v};
         default: ld_val = mem_rdata;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      we_d     = we_q;
      funct3_d = funct3_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      wmask_d  = wmask_q;
      rd_d     = rd_q;
      cnt_d    = cnt_q;
      rf_en_d  = 1'b0;
      rdata_d  = rdata_q;
      err_d    = 1'b0;
      cause_d  = cause_q;
      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               we_d     = req_we;
               funct3_d = req_funct3;
               addr_d   = req_addr;
               rd_d     = req_rd;
               case (req_funct3[1:0])
                  2'b00: begin
                     wdata_d = {4{req_wdata[7:0]}};
                     wmask_d = 4'b0001 << req_addr[1:0];
                  end
                  2'b01: begin
                     wdata_d = {2{req_wdata[15:0]}};
                     wmask_d = 4'b0011 << req_addr[1:0];
                  end
                  default: begin
                     wdata_d = req_wdata;
                     wmask_d = 4'b1111;
                  end
               endcase
               if (!req_we) wmask_d = 4'b0000;
               if (illegal) begin
                  err_d   = 1'b1;
                  cause_d = 2'b10;
               end else if (misaligned) begin
                  err_d   = 1'b1;
                  cause_d = 2'b01;
               end else begin
                  state_d = S_REQ;
                  cnt_d   = '0;
               end
            end
         end
         S_REQ: begin
            if (mem_gnt) begin
               state_d = we_q ? S_IDLE : S_WAIT;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = S_IDLE;
               err_d   = 1'b1;
               cause_d = 2'b11;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_WAIT: begin
            if (mem_rvalid) begin
               state_d = S_RESP;
               rf_en_d = (rd_q != 5'd0);
               rdata_d = ld_val;
            end else if (cnt_q == CNT_LAST) begin
               state_d = S_IDLE;
               err_d   = 1'b1;
               cause_d = 2'b11;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         we_q     <= 1'b0;
         funct3_q <= 3'b000;
         addr_q   <= 32'h0;
         wdata_q  <= 32'h0;
         wmask_q  <= 4'b0000;
         rd_q     <= 5'd0;
         cnt_q    <= '0;
         rf_en_q  <= 1'b0;
         rdata_q  <= 32'h0;
         err_q    <= 1'b0;
         cause_q  <= 2'b00;
      end else begin
         state_q  <= state_d;
         we_q     <= we_d;
         funct3_q <= funct3_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         wmask_q  <= wmask_d;
         rd_q     <= rd_d;
         cnt_q    <= cnt_d;
         rf_en_q  <= rf_en_d;
         rdata_q  <= rdata_d;
         err_q    <= err_d;
         cause_q  <= cause_d;
      end
   end

   assign req_ready = (state_q == S_IDLE);
   assign mem_req   = (state_q == S_REQ);
   assign mem_we    = we_q;
   assign mem_addr  = {addr_q[31:2], 2'b00};
   assign mem_wdata = wdata_q;
   assign mem_wmask = wmask_q;
   assign rf_en     = rf_en_q;
   assign rd        = rd_q;
   assign wdata     = rdata_q;
   assign err       = err_q;
   assign err_cause = cause_q;

endmodule

// File: doc/lsu.md
# lsu

Load/store unit sitting between the execute stage and the register file write port. It accepts one memory instruction at a time from execute over a valid/ready handshake and issues a word-aligned request to data memory with byte lanes. For loads, it waits for the read data, then extracts, sign- or zero-extends it and produces the single-cycle register-file write (`rf_en`, `rd`, `wdata`). Misaligned, illegal and timed-out accesses are reported on an error pulse and never write the register file.

## Interface
- `TIMEOUT`, default 16: maximum number of cycles spent in REQ or WAIT before the access is aborted.
- `clk` in 1: clock, all state on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req_valid` in 1: execute presents a memory instruction.
- `req_ready` out 1: LSU can accept; equals (state==IDLE).
- `req_we` in 1: 1 = store, 0 = load.
- `req_funct3` in 3: RV32I funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW).
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data (rs2).
- `req_rd` in 5: load destination register.
- `mem_req` out 1: memory request, held until granted.
- `mem_we` out 1: request is a store.
- `mem_addr` out 32: {req_addr[31:2], 2'b00}.
- `mem_wdata` out 32: store data shifted to byte lanes.
- `mem_wmask` out 4: byte enables; 4'b0000 for loads.
- `mem_gnt` in 1: memory accepted the request this cycle.
- `mem_rvalid` in 1: load data valid this cycle.
- `mem_rdata` in 32: load word.
- `rf_en` out 1: register-file write enable, one-cycle pulse.
- `rd` out 5: write address.
- `wdata` out 32: write data.
- `err` out 1: one-cycle error pulse.
- `err_cause` out 2: 01 misaligned, 10 illegal funct3, 11 timeout; valid when `err`=1.

## Operation
- States: IDLE, REQ, WAIT, RESP. Reset puts the FSM in IDLE. All registered outputs reset to 0; `req_ready`=1 once `rst` is released.
- IDLE: on `req_valid`&&`req_ready`, latch we/funct3/addr/wdata/rd and check the access.
  - Illegal: load funct3 ∈ {011,110,111}, or store funct3 ∉ {000,001,010}. Set `err`=1, `err_cause`=10 next cycle; stay in IDLE.
  - Misaligned: halfword with addr[0]=1, or word with addr[1:0]≠0. Set `err`=1, `err_cause`=01 next cycle; stay in IDLE. Illegal takes priority over misaligned.
  - Otherwise go to REQ.
- REQ: `mem_req`=1 with stable addr/we/wdata/wmask.
  - On `mem_gnt`: a store returns to IDLE; a load goes to WAIT.
- Store lanes:
  - SB: wdata = {4{b}}, wmask = 0001<<addr[1:0].
  - SH: wdata = {2{h}}, wmask = 0011<<addr[1:0].
  - SW: wmask = 1111.
- WAIT: on `mem_rvalid`, extract data using the latched addr[1:0] and funct3, then go to RESP.
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
  - `mem_rvalid` in the same cycle as `mem_gnt` is ignored; data is accepted from the cycle after the grant.
- RESP: `rf_en`=1 for exactly one cycle with `rd`/`wdata` registered, then IDLE. If the latched rd==0, `rf_en` stays 0; the access still completes.
- Timeout: a counter clears on entering REQ or WAIT and increments each cycle without completion. When it reaches TIMEOUT-1 with no gnt/rvalid, go to IDLE and pulse `err`=1, `err_cause`=11. No rf write occurs.
- `rf_en` and `err` are never both 1.

## Timing
- Handshake: the request is accepted at edge N. `mem_req` rises in cycle N+1 and is held until the edge where `mem_gnt`=1; `mem_req` is 0 in the following cycle.
- Store, zero-wait memory: accept at N, gnt at N+1, `req_ready`=1 again in N+2. Throughput is one store per 2 cycles.
- Load, gnt at N+1 and rvalid at N+2: `rf_en` is high in cycle N+3 and `req_ready`=1 in N+4. Minimum load latency is 3 cycles from accept to the write.
- Error pulse appears the cycle after detection. `req_ready` remains 1 for illegal/misaligned requests, so back-to-back requests are allowed.
- Outputs are registered; `req_ready` is decoded from the state register.
- Reset mid-operation: all state clears immediately and asynchronously. Any in-flight request is abandoned, and `mem_req`/`rf_en`/`err` drop to 0 while `rst` is high.
- A `mem_rvalid` arriving outside WAIT is ignored.

## Test plan
- LW addr 0x100, mem_rdata 0xDEADBEEF, gnt and rvalid with zero wait -> `rf_en`=1 three cycles after accept, `rd`=5, `wdata`=0xDEADBEEF, `mem_wmask`=0000.
- LB/LBU addr 0x103, mem_rdata 0x80FF7F01 -> LB wdata 0xFFFFFF80; LBU wdata 0x00000080. LH addr 0x102 -> 0xFFFF80FF.
- SB addr 0x201, req_wdata 0x000000AB -> `mem_addr` 0x200, `mem_wdata` 0xABABABAB, `mem_wmask` 0010, no `rf_en`. SH addr 0x202 -> mask 1100.
- Misaligned and illegal requests:
  - LW addr 0x102 -> `err`=1, `err_cause`=01, no `mem_req`.
  - Load funct3=011 -> `err_cause`=10.
  - LB with rd=0 -> access completes, `rf_en`=0.
- Backpressure and timeout:
  - Hold `mem_gnt`=0 for 5 cycles -> `mem_req` and `mem_addr` stay stable, completes normally.
  - With TIMEOUT=16, withhold rvalid -> `err_cause`=11 after 16 WAIT cycles, `req_ready` returns to 1, no `rf_en`.
- Assert `rst` while in WAIT -> outputs clear immediately; after release, a new LW completes correctly and a stale rvalid is ignored.
